fpu_op_sequencer: RTL
=====================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 The module SHALL have the parameter TIMEOUT_CYCLES, default 64, meaning the number of WAIT cycles before the operation is abandoned (range 2..65535).
REQ-002 The module SHALL have these ports:
  clk  input  1  single clock; all state on its rising edge
  rst_n  input  1  reset, asynchronous, active-low
  req_valid  input  1  upstream request present
  req_ready  output  1  sequencer accepts a request this cycle
  req_a, req_b  input  32 each  IEEE-754 single operands (req_b ignored for sqrt)
  req_op  input  3  operation code (package constants)
  req_mode  input  3  fpu_round_mode_t rounding mode
  unit_valid  output  1  one-cycle start pulse to the arithmetic unit
  unit_sel  output  4  one-hot unit select {sqrt,div,mult,add}
  unit_a, unit_b  output  32 each  registered operands
  unit_mode  output  3  registered rounding mode
  unit_ready  input  1  one-cycle result pulse from the selected unit
  unit_y  input  32  unit result, valid when unit_ready=1
  rsp_valid  output  1  response present
  rsp_ready  input  1  downstream accepts the response
  rsp_y  output  32  result word
  rsp_status  output  2  OK=0, BAD_OP=1, TIMEOUT=2
  rsp_cycles  output  16  cycle count from issue to result

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, req_valid&&req_ready SHALL register a, b, op and mode; a valid op SHALL go to ISSUE and an undefined op SHALL go to RESP with status BAD_OP, rsp_y=32'h7FC00000 and rsp_cycles=0, and no unit_valid.
REQ-005 ISSUE SHALL last exactly one cycle with unit_valid=1 and the decoded unit_sel; the cycle counter SHALL load 1; the next state SHALL be WAIT, unless unit_ready=1 in that cycle, in which case it SHALL be RESP.
REQ-006 In WAIT, a unit_ready=1 SHALL capture unit_y into rsp_y, the counter into rsp_cycles and status OK, then go to RESP; otherwise the counter SHALL increment, saturating at 16'hFFFF.
REQ-007 unit_a, unit_b, unit_mode and unit_sel SHALL stay stable from ISSUE through WAIT; unit_sel SHALL be 0 in IDLE and RESP.
REQ-008 In RESP, rsp_valid SHALL be 1 with rsp_y, rsp_status and rsp_cycles held stable; rsp_valid&&rsp_ready SHALL return to IDLE, and the earliest next req_ready SHALL be the following cycle.
REQ-009 unit_ready SHALL be ignored in IDLE and RESP, including a late pulse after a timeout.
REQ-010 Exactly one operation SHALL be in flight; there SHALL be no overlap or reordering.

Reset
REQ-011 While rst_n=0 (asynchronous assert), the state SHALL be IDLE, every output SHALL be 0 except req_ready (0 during reset, 1 in the first IDLE cycle after release), and the counter and registers SHALL be 0.
REQ-012 Reset asserted mid-operation SHALL abandon it with no response; a late unit_ready after release SHALL be ignored (REQ-009).

Configuration
REQ-013 With FPU_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES in WAIT with no unit_ready, the next state SHALL be RESP with status TIMEOUT, rsp_y=32'h7FC00000 and rsp_cycles=TIMEOUT_CYCLES.
REQ-014 When the macro is undefined, WAIT SHALL persist until unit_ready, the TIMEOUT status SHALL never occur, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-015 Package fpu_seq_pkg SHALL hold the state enum, the status enum, the op codes (ADD=0, MULT=1, DIV=2, SQRT=3; codes 4-7 invalid), the unit_sel one-hot constants and FPU_CANONICAL_NAN=32'h7FC00000; fpu_round_mode_t SHALL come from the fpu package.
REQ-016 The counter, saturation and timeout compare SHALL form one sub-module, fpu_seq_watchdog, with inputs clear/load/enable and outputs count and expired.

Verification
REQ-017 ADD a=3F800000, b=40000000, mode RNE, with a unit model returning 40400000 three cycles after unit_valid -> one unit_valid pulse, unit_sel=0001, rsp_y=40400000, status OK, rsp_cycles=3.
REQ-018 SQRT a=41C80000, model latency 27 -> unit_sel=1000, rsp_y=40A00000, rsp_cycles=27; req_ready=0 throughout.
REQ-019 req_op=5 -> unit_valid never asserted, status BAD_OP, rsp_y=7FC00000, rsp_cycles=0.
REQ-020 FPU_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a silent model -> TIMEOUT with rsp_cycles=8; a model pulse at cycle 10 is ignored, and the next ADD completes normally.
REQ-021 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; released -> IDLE the next cycle.
REQ-022 rst_n pulsed low during WAIT of a DIV -> outputs 0 immediately, no rsp_valid, later unit_ready ignored.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types used by the arithmetic units and by their sequencer.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fpu_round_mode_t;

endpackage

// File: rtl/fpu_seq_pkg.sv
// Types and constants for the FPU operation sequencer (fpu_op_sequencer).
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } fpu_seq_state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_BAD_OP  = 2'd1,
    STAT_TIMEOUT = 2'd2
  } fpu_seq_status_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_SQRT = 3'd3;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_ADD  = 4'b0001;
  localparam logic [3:0] SEL_MULT = 4'b0010;
  localparam logic [3:0] SEL_DIV  = 4'b0100;
  localparam logic [3:0] SEL_SQRT = 4'b1000;

  localparam logic [31:0] FPU_CANONICAL_NAN = 32'h7FC0_0000;

  // Codes 4..7 have no unit and decode to SEL_NONE.
  function automatic logic [3:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  return SEL_ADD;
      OP_MULT: return SEL_MULT;
      OP_DIV:  return SEL_DIV;
      OP_SQRT: return SEL_SQRT;
      default: return SEL_NONE;
    endcase
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return op_to_sel(op) != SEL_NONE;
  endfunction

endpackage

// File: rtl/fpu_seq_watchdog.sv
// Issue-to-result cycle counter with saturation and optional timeout compare.
// Timeout compare is active only when FPU_SEQ_TIMEOUT_EN is defined.
module fpu_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        enable,
  output logic [15:0] count,
  output logic        expired
);

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = 16'd1;
    end else if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = TIMEOUT_EN && (count_q == LIMIT);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Sequences one FPU operation at a time: accept, issue to a unit, wait, respond.
// Define FPU_SEQ_TIMEOUT_EN to abandon operations after TIMEOUT_CYCLES wait cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; captures operands on handshake
// S_ISSUE | one-cycle start pulse to the selected unit, counter = 1
// S_WAIT  | counting cycles until unit_ready (or timeout)
// S_RESP  | response held until rsp_ready
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic [2:0]               req_op,
  input  fpu_pkg::fpu_round_mode_t req_mode,
  output logic                     unit_valid,
  output logic [3:0]               unit_sel,
  output logic [31:0]              unit_a,
  output logic [31:0]              unit_b,
  output fpu_pkg::fpu_round_mode_t unit_mode,
  input  logic                     unit_ready,
  input  logic [31:0]              unit_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_y,
  output logic [1:0]               rsp_status,
  output logic [15:0]              rsp_cycles
);

  fpu_seq_state_e           state_q, state_d;
  logic [31:0]              a_q, a_d;
  logic [31:0]              b_q, b_d;
  logic [2:0]               op_q, op_d;
  fpu_pkg::fpu_round_mode_t mode_q, mode_d;
  logic [31:0]              rsp_y_q, rsp_y_d;
  fpu_seq_status_e          rsp_status_q, rsp_status_d;
  logic [15:0]              rsp_cycles_q, rsp_cycles_d;

  logic        wd_clear, wd_load, wd_enable, wd_expired;
  logic [15:0] wd_count;

  fpu_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .load   (wd_load),
    .enable (wd_enable),
    .count  (wd_count),
    .expired(wd_expired)
  );

  // Gated with rst_n so ready stays low while reset is held.
  assign req_ready = rst_n && (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    mode_d       = mode_q;
    rsp_y_d      = rsp_y_q;
    rsp_status_d = rsp_status_q;
    rsp_cycles_d = rsp_cycles_q;
    wd_clear     = 1'b0;
    wd_load      = 1'b0;
    wd_enable    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          a_d      = req_a;
          b_d      = req_b;
          op_d     = req_op;
          mode_d   = req_mode;
          wd_clear = 1'b1;
          if (op_is_valid(req_op)) begin
            state_d = S_ISSUE;
          end else begin
            state_d      = S_RESP;
            rsp_y_d      = FPU_CANONICAL_NAN;
            rsp_status_d = STAT_BAD_OP;
            rsp_cycles_d = '0;
          end
        end
      end
      S_ISSUE: begin
        wd_load = 1'b1;
        if (unit_ready) begin
          state_d      = S_RESP;
          rsp_y_d      = unit_y;
          rsp_status_d = STAT_OK;
          rsp_cycles_d = 16'd1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (unit_ready) begin
          state_d      = S_RESP;
          rsp_y_d      = unit_y;
          rsp_status_d = STAT_OK;
          rsp_cycles_d = wd_count;
        end else if (wd_expired) begin
          state_d      = S_RESP;
          rsp_y_d      = FPU_CANONICAL_NAN;
          rsp_status_d = STAT_TIMEOUT;
          rsp_cycles_d = wd_count;
        end else begin
          wd_enable = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      mode_q       <= fpu_pkg::RM_RNE;
      rsp_y_q      <= '0;
      rsp_status_q <= STAT_OK;
      rsp_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      mode_q       <= mode_d;
      rsp_y_q      <= rsp_y_d;
      rsp_status_q <= rsp_status_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign unit_valid = (state_q == S_ISSUE);
  assign unit_sel   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? op_to_sel(op_q) : SEL_NONE;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign unit_mode  = mode_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_y      = rsp_y_q;
  assign rsp_status = rsp_status_q;
  assign rsp_cycles = rsp_cycles_q;

endmodule
